// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and the transmitter state encoding.
// Imported by uart_tx, uart_rx and interface_circuit.
package uart_pkg;

    localparam int NBITS_DEF      = 8;
    localparam int NUM_TICKS_DEF  = 16;
    localparam int STOP_TICKS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one start bit, NBITS data bits LSB-first, then a STOP_TICKS stop period,
// all paced by the shared 16x oversampling baud tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int NBITS      = NBITS_DEF,
    parameter int NUM_TICKS  = NUM_TICKS_DEF,
    parameter int STOP_TICKS = STOP_TICKS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_tick,
    input  logic             tx_start,
    input  logic [NBITS-1:0] din,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done_tick
);

    localparam int SMAX = (NUM_TICKS > STOP_TICKS) ? NUM_TICKS : STOP_TICKS;
    localparam int SW   = (SMAX > 2) ? $clog2(SMAX) : 1;
    localparam int NW   = (NBITS > 2) ? $clog2(NBITS) : 1;

    localparam logic [SW-1:0] S_LAST  = SW'(NUM_TICKS - 1);
    localparam logic [SW-1:0] ST_LAST = SW'(STOP_TICKS - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(NBITS - 1);

    tx_state_e        state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [NW-1:0]    n_q, n_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                // A tick coinciding with acceptance is deliberately not counted.
                if (tx_start) begin
                    shreg_d = din;
                    s_d     = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        tx_d    = shreg_q[0];
                        state_d = DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        shreg_d = shreg_q >> 1;
                        if (n_q == N_LAST) begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end else begin
                            n_d  = n_q + NW'(1);
                            tx_d = shreg_q[1];
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (s_q == ST_LAST) begin
                        s_d     = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign tx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level reference model checks tx/tx_busy/tx_done_tick every cycle,
// and a byte scoreboard matches bytes decoded at bit centres against the bytes that were sent.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    logic       tx, tx_busy, tx_done_tick;
    logic       tx_start1;
    logic [6:0] din1;
    logic       tx1, tx_busy1, tx_done_tick1;

    uart_tx dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .tx_start     (tx_start),
        .din          (din),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    uart_tx #(.NBITS(7), .NUM_TICKS(16), .STOP_TICKS(32)) dut7 (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .tx_start     (tx_start1),
        .din          (din1),
        .tx           (tx1),
        .tx_busy      (tx_busy1),
        .tx_done_tick (tx_done_tick1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick generator: period 1 means s_tick tied high, period N means one pulse every N clocks.
    int tick_period = 1;
    int tick_cnt    = 0;
    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (tick_period <= 1) begin
                s_tick = 1'b1;
            end else begin
                s_tick   = (tick_cnt == tick_period - 1);
                tick_cnt = (tick_cnt == tick_period - 1) ? 0 : tick_cnt + 1;
            end
        end
    end

    // Reference model state, index 0 = 8-bit/1-stop instance, 1 = 7-bit/2-stop instance.
    logic       mst[2];
    int         mt[2];
    logic [7:0] cur[2];
    logic [7:0] dec[2];
    int         acc_cnt[2];
    int         done_cnt[2];
    int         acc_cyc[2];
    int         done_cyc[2];
    int         cyc = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    task automatic model_step(input int id, input logic tk, input logic rs, input logic st,
                              input logic [7:0] d, input logic otx, input logic obusy,
                              input logic odone);
        int nb, stp, fin, b;
        logic etx, edone;
        logic [7:0] e;
        nb    = (id == 0) ? 8 : 7;
        stp   = (id == 0) ? 16 : 32;
        fin   = (nb + 1) * 16 + stp;
        edone = 1'b0;
        if (!rs) begin
            // An abandoned frame never completes, so its scoreboard entry is dropped.
            if (mst[id]) begin
                if (id == 0 && q0.size() > 0) void'(q0.pop_front());
                if (id == 1 && q1.size() > 0) void'(q1.pop_front());
            end
            mst[id] = 1'b0;
        end else if (!mst[id]) begin
            if (st) begin
                mst[id] = 1'b1;
                mt[id]  = 0;
                cur[id] = d;
                dec[id] = '0;
                acc_cnt[id]++;
                acc_cyc[id] = cyc;
            end
        end else if (tk) begin
            mt[id]++;
            b = mt[id] / 16;
            if (mt[id] % 16 == 8) begin
                if (b == 0)           check_eq("start_centre", otx, 0);
                else if (b <= nb)     dec[id][b-1] = otx;
                else if (b == nb + 1) check_eq("stop_centre", otx, 1);
            end
            if (mt[id] == fin) begin
                mst[id]  = 1'b0;
                edone    = 1'b1;
                done_cnt[id]++;
                done_cyc[id] = cyc;
                e = '0;
                if (id == 0) begin
                    check_eq("sb_avail0", q0.size() > 0, 1);
                    if (q0.size() > 0) e = q0.pop_front();
                end else begin
                    check_eq("sb_avail1", q1.size() > 0, 1);
                    if (q1.size() > 0) e = q1.pop_front();
                end
                check_eq((id == 0) ? "sb_byte0" : "sb_byte1", dec[id], e);
            end
        end
        if (!mst[id]) begin
            etx = 1'b1;
        end else begin
            b = mt[id] / 16;
            if (b == 0)       etx = 1'b0;
            else if (b <= nb) etx = cur[id][b-1];
            else              etx = 1'b1;
        end
        check_eq((id == 0) ? "tx0" : "tx1", otx, etx);
        check_eq((id == 0) ? "busy0" : "busy1", obusy, mst[id]);
        check_eq((id == 0) ? "done0" : "done1", odone, edone);
    endtask

    // Inputs are driven on the falling edge, so they are stable when captured here.
    initial begin
        logic tk, rs, st0, st1;
        logic [7:0] d0, d1;
        for (int i = 0; i < 2; i++) begin
            mst[i] = 1'b0; mt[i] = 0; cur[i] = '0; dec[i] = '0;
            acc_cnt[i] = 0; done_cnt[i] = 0; acc_cyc[i] = 0; done_cyc[i] = 0;
        end
        forever begin
            @(posedge clk);
            tk  = s_tick;
            rs  = reset;
            st0 = tx_start;
            d0  = din;
            st1 = tx_start1;
            d1  = {1'b0, din1};
            cyc++;
            #1;
            model_step(0, tk, rs, st0, d0, tx, tx_busy, tx_done_tick);
            model_step(1, tk, rs, st1, d1, tx1, tx_busy1, tx_done_tick1);
        end
    end

    task automatic send0(input logic [7:0] b);
        @(negedge clk);
        din      = b;
        tx_start = 1'b1;
        q0.push_back(b);
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic send1(input logic [6:0] b);
        @(negedge clk);
        din1      = b;
        tx_start1 = 1'b1;
        q1.push_back({1'b0, b});
        @(negedge clk);
        tx_start1 = 1'b0;
    endtask

    task automatic wait_idle(input int id, input int maxc);
        int k;
        k = 0;
        while (mst[id] && k < maxc) begin
            @(negedge clk);
            k++;
        end
        check_eq("wait_idle", mst[id], 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        reset     = 1'b0;
        tx_start  = 1'b0;
        din       = '0;
        tx_start1 = 1'b0;
        din1      = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_done", tx_done_tick, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame at full tick rate
        tick_period = 1;
        dc = done_cnt[0];
        send0(8'h55);
        wait_idle(0, 400);
        check_eq("frame_len_8n1", done_cyc[0] - acc_cyc[0], 160);
        check_eq("done_cnt_55", done_cnt[0] - dc, 1);
        repeat (5) @(negedge clk);

        // Real baud timing
        tick_period = 16;
        send0(8'h03);
        wait_idle(0, 4000);
        tick_period = 1;
        repeat (5) @(negedge clk);

        // Request mid-frame is ignored
        dc = done_cnt[0];
        send0(8'h00);
        repeat (50) @(negedge clk);
        din      = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        wait_idle(0, 400);
        repeat (40) @(negedge clk);
        check_eq("ignored_done_cnt", done_cnt[0] - dc, 1);
        check_eq("ignored_no_frame", tx_busy, 0);
        check_eq("ignored_sb_empty", q0.size(), 0);

        // Reset during data bit 3 of 0xA5
        dc = done_cnt[0];
        send0(8'hA5);
        repeat (16 + 16 * 3 + 6) @(negedge clk);
        check_eq("pre_abort_busy", tx_busy, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("abort_tx", tx, 1);
        check_eq("abort_busy", tx_busy, 0);
        repeat (3) @(negedge clk);
        send0(8'h3C);
        wait_idle(0, 400);
        check_eq("abort_done_cnt", done_cnt[0] - dc, 1);
        repeat (5) @(negedge clk);

        // Held request: back-to-back frames, din changed after first acceptance
        dc = done_cnt[0];
        begin
            int a, k;
            a = acc_cnt[0];
            @(negedge clk);
            din      = 8'h81;
            tx_start = 1'b1;
            q0.push_back(8'h81);
            q0.push_back(8'h7E);
            @(negedge clk);
            din = 8'h7E;
            k = 0;
            while (acc_cnt[0] < a + 2 && k < 400) begin
                @(negedge clk);
                k++;
            end
            tx_start = 1'b0;
            check_eq("b2b_accepts", acc_cnt[0] - a, 2);
            check_eq("b2b_gap", acc_cyc[0] - done_cyc[0], 1);
        end
        wait_idle(0, 400);
        check_eq("b2b_done_cnt", done_cnt[0] - dc, 2);
        repeat (5) @(negedge clk);

        // 7 data bits, two stop bits
        dc = done_cnt[1];
        send1(7'h41);
        wait_idle(1, 400);
        check_eq("frame_len_7n2", done_cyc[1] - acc_cyc[1], 160);
        check_eq("done_cnt_7n2", done_cnt[1] - dc, 1);

        repeat (5) @(negedge clk);
        check_eq("sb_empty0", q0.size(), 0);
        check_eq("sb_empty1", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the UART path.
- Takes the byte presented by interface_circuit on data_out/tx_start and serialises it on the tx line: 1 start bit, NBITS data bits LSB-first, then a stop period.
- Timing comes from the shared 16x oversampling baud tick, the same tick the receiver uses.
- Pulses tx_done_tick back to the interface when the frame is complete.

Parameters:
- NBITS, 8: data bits per frame.
- NUM_TICKS, 16: s_tick pulses per start bit and per data bit (oversampling factor).
- STOP_TICKS, 16: s_tick pulses in the stop period (16 = 1 stop bit, 32 = 2 stop bits).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- s_tick  in  1  baud oversampling tick, one-cycle pulse, NUM_TICKS per bit time.
- tx_start  in  1  request to send din; sampled only in IDLE.
- din  in  NBITS  byte to transmit; captured on the accepting edge.
- tx  out  1  serial line, registered, idle high.
- tx_busy  out  1  high whenever state != IDLE.
- tx_done_tick  out  1  one-cycle registered pulse at end of frame.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, tx=1, tx_done_tick=0, tx_busy=0, tick counter s=0, bit counter n=0, shift register=0. Reset has priority over everything, including mid-frame: tx returns high on the next cycle and the partial frame is abandoned.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE
  - tx=1.
  - On an edge with tx_start=1: shift register <= din, s <= 0, tx <= 0, state <= START.
  - s_tick in the same cycle is not counted.
- START
  - On each edge with s_tick=1: if s==NUM_TICKS-1, then s<=0, n<=0, tx<=shreg[0], state<=DATA; else s<=s+1.
  - Edges without s_tick hold all state.
- DATA
  - On s_tick with s==NUM_TICKS-1: s<=0 and shreg<=shreg>>1.
    - If n==NBITS-1: tx<=1, state<=STOP.
    - Else: n<=n+1, tx<=next bit (LSB-first).
  - Otherwise, on s_tick: s<=s+1.
- STOP
  - tx=1.
  - On s_tick with s==STOP_TICKS-1: state<=IDLE, s<=0, tx_done_tick<=1.
  - Otherwise, on s_tick: s<=s+1.
- tx_done_tick is high for exactly one cycle; it is 0 in every other cycle.
- tx_start outside IDLE is ignored; there is no queuing.
  - tx_start in the same cycle tx_done_tick is registered is ignored.
  - A tx_start held high restarts on the first IDLE cycle, giving exactly 1 idle cycle between frames.
- din changes after acceptance have no effect on the frame in flight.
- Counter widths: s is clog2(max(NUM_TICKS,STOP_TICKS)) bits; n is clog2(NBITS) bits.
- Latency with s_tick tied high:
  - Accept at edge 0.
  - tx low for cycles 1..16.
  - Bit i occupies cycles 17+16i .. 32+16i.
  - tx high from cycle 145.
  - tx_done_tick high in the cycle following edge 160.
  - Total frame = (1+NBITS)*NUM_TICKS + STOP_TICKS cycles.

Decomposition:
- Shared package (uart_pkg), shared with uart_rx and interface_circuit:
  - NBITS and NUM_TICKS defaults.
  - STOP_TICKS default.
  - State encoding localparams IDLE/START/DATA/STOP.
- No sub-module. s_tick comes from the existing baud-rate generator, instantiated at top level.

Test Plan:
- Single frame, din=0x55, s_tick tied high → tx low for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16 cycles; tx_done_tick=1 for exactly one cycle, 161 cycles after acceptance; tx_busy high throughout the frame.
- Real baud timing, s_tick one pulse every 16 clocks, din=0x03 → each bit lasts 256 clocks; sampling at bit centres yields start=0, data 1,1,0,0,0,0,0,0, stop=1.
- tx_start pulsed with din=0xFF in the middle of a 0x00 frame → the 0x00 frame is unchanged; only one tx_done_tick; no 0xFF frame follows.
- Reset asserted (reset=0) during DATA bit 3 of 0xA5 → next cycle tx=1, tx_busy=0, no tx_done_tick; a subsequent tx_start with 0x3C produces a clean 0x3C frame.
- tx_start held high, din=0x81 then 0x7E changed after the first acceptance, s_tick high → two back-to-back frames 0x81 then 0x7E with exactly 1 idle-high cycle between them; two tx_done_tick pulses.
- NBITS=7, STOP_TICKS=32 instance, din=0x41 → 7 data bits then 32 cycles of stop high; total frame 160 cycles.
